// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and pixel type for vga_ctrl.
// Optional running light period is used only when LIGHT_EN is defined.
package vga_pkg;

  localparam int ACT_W        = 640;
  localparam int ACT_H        = 480;

  localparam int H_SYNC       = 96;
  localparam int H_ACT_START  = 144;
  localparam int H_ACT_END    = H_ACT_START + ACT_W;
  localparam int H_TOTAL      = 800;

  localparam int V_SYNC       = 2;
  localparam int V_ACT_START  = 35;
  localparam int V_ACT_END    = V_ACT_START + ACT_H;
  localparam int V_TOTAL      = 525;

  localparam int LIGHT_PERIOD = 5000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_ctrl_if.sv
// Frame-memory / DAC side bundle of vga_ctrl: pixel address out,
// pixel data in, sync/blank and gated RGB out.
interface vga_ctrl_if;

  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    input  vga_data,
    output h_addr, v_addr,
    output hsync, vsync, valid,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    output vga_data,
    input  h_addr, v_addr,
    input  hsync, vsync, valid,
    input  vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_ctrl_light.sv
// Running-light LED driver (built only with LIGHT_EN): one-hot led
// rotates left every PERIOD clocks. Ports: clk, reset (async low), led.
`ifdef LIGHT_EN
module light
  import vga_pkg::*;
#(
  parameter int PERIOD = LIGHT_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] led
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      led <= 16'h0001;
    end else if (cnt == LAST) begin
      cnt <= '0;
      led <= {led[14:0], led[15]};
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/vga_ctrl.sv
// VGA timing generator: pclk, reset (async low), vga (ctrl_if master),
// and led[15:0] plus the light sub-block when LIGHT_EN is defined.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int HS_LEN = H_SYNC,
  parameter int HA_BEG = H_ACT_START,
  parameter int HA_END = H_ACT_END,
  parameter int H_TOT  = H_TOTAL,
  parameter int VS_LEN = V_SYNC,
  parameter int VA_BEG = V_ACT_START,
  parameter int VA_END = V_ACT_END,
  parameter int V_TOT  = V_TOTAL
`ifdef LIGHT_EN
  ,
  parameter int L_PER  = LIGHT_PERIOD
`endif
) (
  input  logic        pclk,
  input  logic        reset,
  vga_ctrl_if.master  vga
`ifdef LIGHT_EN
  ,
  output logic [15:0] led
`endif
);

  localparam logic [9:0] HS  = 10'(HS_LEN);
  localparam logic [9:0] HB  = 10'(HA_BEG);
  localparam logic [9:0] HE  = 10'(HA_END);
  localparam logic [9:0] HT1 = 10'(H_TOT - 1);
  localparam logic [9:0] VS  = 10'(VS_LEN);
  localparam logic [9:0] VB  = 10'(VA_BEG);
  localparam logic [9:0] VE  = 10'(VA_END);
  localparam logic [9:0] VT1 = 10'(V_TOT - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_act;
  logic       v_act;
  logic       act;
  rgb_t       px;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HT1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VT1) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Pure decode of the counters: reset holds both at 0, which
  // already yields low syncs, blanking and zero addresses.
  assign h_act = (h_cnt >= HB) && (h_cnt < HE);
  assign v_act = (v_cnt >= VB) && (v_cnt < VE);
  assign act   = h_act && v_act;

  assign vga.hsync  = (h_cnt >= HS);
  assign vga.vsync  = (v_cnt >= VS);
  assign vga.valid  = act;
  assign vga.h_addr = h_act ? h_cnt - HB : '0;
  assign vga.v_addr = v_act ? v_cnt - VB : '0;

  assign px = act ? rgb_t'(vga.vga_data) : '0;

  assign vga.vga_r = px.r;
  assign vga.vga_g = px.g;
  assign vga.vga_b = px.b;

`ifdef LIGHT_EN
  light #(
    .PERIOD (L_PER)
  ) u_light (
    .clk   (pclk),
    .reset (reset),
    .led   (led)
  );
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl: full-size and shrunken-timing DUTs
// fed random pixels, checked against a modular-arithmetic model.
module tb_vga_ctrl;
  import vga_pkg::*;

  typedef struct {
    int          t;
    logic [9:0]  ha;
    logic [9:0]  va;
    logic        hs;
    logic        vs;
    logic        vl;
    logic [23:0] rgb;
    logic [15:0] led;
  } exp_t;

  logic pclk = 1'b0;
  logic reset;
  logic [23:0] d;
  int t;
  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #20 pclk = ~pclk;

  vga_ctrl_if bus_a ();
  vga_ctrl_if bus_b ();

`ifdef LIGHT_EN
  logic [15:0] led_a, led_b;
`endif

  vga_ctrl dut_a (
    .pclk  (pclk),
    .reset (reset),
    .vga   (bus_a)
`ifdef LIGHT_EN
    ,
    .led   (led_a)
`endif
  );

  vga_ctrl #(
    .HS_LEN (4),
    .HA_BEG (7),
    .HA_END (15),
    .H_TOT  (18),
    .VS_LEN (2),
    .VA_BEG (3),
    .VA_END (7),
    .V_TOT  (9)
`ifdef LIGHT_EN
    ,
    .L_PER  (4)
`endif
  ) dut_b (
    .pclk  (pclk),
    .reset (reset),
    .vga   (bus_b)
`ifdef LIGHT_EN
    ,
    .led   (led_b)
`endif
  );

  // Position in the frame is just cycles-since-release modulo the
  // line and frame lengths.
  function automatic exp_t model(int tc, int hs, int hb, int he, int ht,
                                 int vs, int vb, int ve, int vt, int lp,
                                 logic [23:0] px);
    exp_t m;
    int h = tc % ht;
    int ln = (tc / ht) % vt;
    bit hin = (h >= hb) && (h < he);
    bit vin = (ln >= vb) && (ln < ve);
    m.t   = tc;
    m.hs  = (h >= hs);
    m.vs  = (ln >= vs);
    m.vl  = hin && vin;
    m.ha  = hin ? 10'(h - hb) : 10'd0;
    m.va  = vin ? 10'(ln - vb) : 10'd0;
    m.rgb = m.vl ? px : 24'h0;
    m.led = 16'h0001 << ((tc / lp) % 16);
    return m;
  endfunction

  task automatic push();
    qa.push_back(model(t, H_SYNC, H_ACT_START, H_ACT_END, H_TOTAL,
                       V_SYNC, V_ACT_START, V_ACT_END, V_TOTAL,
                       LIGHT_PERIOD, d));
    qb.push_back(model(t, 4, 7, 15, 18, 2, 3, 7, 9, 4, d));
    run = 1'b1;
  endtask

  task automatic step(input bit rst_next);
    @(posedge pclk);
    if (reset) t++;
    #1;
    if (!rst_next && reset) t = 0;
    reset = rst_next;
    if (((t / 1000) % 3) == 1) d = 24'hA1B2C3;
    else d = 24'($urandom);
    bus_a.vga_data = d;
    bus_b.vga_data = d;
    push();
  endtask

  task automatic chk(string nm, int tc, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, tc, act, req);
    end
  endtask

  always @(negedge pclk) begin
    if (run) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty actual=%0d required=1", qa.size());
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_h_addr", ea.t, 32'(bus_a.h_addr), 32'(ea.ha));
        chk("a_v_addr", ea.t, 32'(bus_a.v_addr), 32'(ea.va));
        chk("a_hsync", ea.t, 32'(bus_a.hsync), 32'(ea.hs));
        chk("a_vsync", ea.t, 32'(bus_a.vsync), 32'(ea.vs));
        chk("a_valid", ea.t, 32'(bus_a.valid), 32'(ea.vl));
        chk("a_rgb", ea.t, 32'({bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}),
            32'(ea.rgb));
        chk("b_h_addr", eb.t, 32'(bus_b.h_addr), 32'(eb.ha));
        chk("b_v_addr", eb.t, 32'(bus_b.v_addr), 32'(eb.va));
        chk("b_hsync", eb.t, 32'(bus_b.hsync), 32'(eb.hs));
        chk("b_vsync", eb.t, 32'(bus_b.vsync), 32'(eb.vs));
        chk("b_valid", eb.t, 32'(bus_b.valid), 32'(eb.vl));
        chk("b_rgb", eb.t, 32'({bus_b.vga_r, bus_b.vga_g, bus_b.vga_b}),
            32'(eb.rgb));
`ifdef LIGHT_EN
        chk("a_led", ea.t, 32'(led_a), 32'(ea.led));
        chk("b_led", eb.t, 32'(led_b), 32'(eb.led));
`endif
      end
    end
  end

  initial begin
    t = 0;
    reset = 1'b0;
    d = 24'h0;
    bus_a.vga_data = d;
    bus_b.vga_data = d;
    repeat (4) step(1'b0);
    repeat (30500) step(1'b1);
    repeat (3) step(1'b0);
    repeat (2200) step(1'b1);
    repeat (2) step(1'b0);
    repeat (400) step(1'b1);
    @(negedge pclk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
